rf_write_arbiter: RTL
=====================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of entries in the long-latency result buffer (power of two, 2..16).
REQ-002 SHALL have parameter STARVE_LIMIT, default 3, meaning the consecutive WB grants allowed while the buffer is non-empty before the buffer is forced through.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wb_we  input  1  WB-stage write request.
REQ-006 SHALL have port wb_rd  input  5  WB-stage destination register.
REQ-007 SHALL have port wb_data  input  32  WB-stage write data.
REQ-008 SHALL have port lu_valid  input  1  long-latency unit (mult/div) result valid.
REQ-009 SHALL have port lu_ready  output  1  buffer can accept a result this cycle.
REQ-010 SHALL have port lu_rd  input  5  long-latency result destination register.
REQ-011 SHALL have port lu_data  input  32  long-latency result data.
REQ-012 SHALL have port rf_we  output  1  register-file write enable.
REQ-013 SHALL have port rf_waddr  output  5  register-file write address.
REQ-014 SHALL have port rf_wdata  output  32  register-file write data.
REQ-015 SHALL have port wb_stall  output  1  WB write not granted; the pipeline holds the WB inputs stable for the next cycle.
REQ-016 SHALL have port chk_rd_a  input  5  hazard-check register A.
REQ-017 SHALL have port chk_rd_b  input  5  hazard-check register B.
REQ-018 SHALL have port pend_a  output  1  chk_rd_a matches a valid buffer entry.
REQ-019 SHALL have port pend_b  output  1  chk_rd_b matches a valid buffer entry.
REQ-020 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH+1)  number of valid buffer entries.

Function
REQ-021 SHALL treat wb_we=1 with wb_rd=0 as no WB request, so that no write is issued and wb_stall=0.
REQ-022 SHALL accept a result when lu_valid && lu_ready at a rising edge: push {lu_rd, lu_data} at the tail if lu_rd!=0, or discard it if lu_rd=0.
REQ-023 SHALL drive lu_ready = (fifo_count < FIFO_DEPTH), independent of same-cycle pops, with no combinational path from lu_valid.
REQ-024 SHALL provide no bypass: an accepted result is written at the earliest one cycle after acceptance.
REQ-025 SHALL select the grant combinationally each cycle with priority (a) forced, (b) WB, (c) FIFO.
- (a) Forced: starve_cnt==STARVE_LIMIT and FIFO non-empty -> grant FIFO head; if a WB request is present, wb_stall=1.
- (b) WB: WB request present -> rf_we=1, rf_waddr=wb_rd, rf_wdata=wb_data.
- (c) FIFO: FIFO non-empty -> rf_we=1, address and data from head; pop at the edge.
- None: rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-026 SHALL update the starve counter at each edge as follows.
- WB granted while FIFO non-empty: increment, saturating at STARVE_LIMIT.
- FIFO granted: clear to 0.
- FIFO empty: clear to 0.
REQ-027 SHALL drive wb_stall=1 only in forced-grant cycles with a WB request present, and 0 otherwise.
REQ-028 SHALL pop the FIFO in strict order with no reordering; the pointers wrap modulo FIFO_DEPTH.
REQ-029 SHALL handle push and pop in the same cycle: count unchanged, both pointers advance; when full, no push occurs because lu_ready=0.
REQ-030 SHALL drive pend_a/pend_b combinationally from all valid entries, including the head being popped this cycle; a check register of 0 returns 0.
REQ-031 SHALL leave WB-versus-buffer ordering to the same register to the hazard unit via pend_a/pend_b; the arbiter does not enforce it.
REQ-032 SHALL have fifo_count equal to pushes minus pops since reset, always within 0..FIFO_DEPTH.

Reset
REQ-033 SHALL, while reset=1, immediately clear the FIFO (count 0, pointers 0) and clear the starve counter to 0.
REQ-034 SHALL, while reset=1, force rf_we=0, wb_stall=0, lu_ready=0, pend_a=0 and pend_b=0 regardless of inputs.
REQ-035 SHALL discard entries on reset mid-operation without writing them; lu_ready=1 on the first cycle after reset deasserts.

Verification
REQ-036 SHALL cover: WB only, wb_we=1, wb_rd=5, wb_data=0x1234 -> the same cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, wb_stall=0.
REQ-037 SHALL cover: lu push rd=8, data=0xCAFE with WB idle -> fifo_count=1 and pend for chk_rd_a=8 is 1; next cycle rf_we=1, rf_waddr=8, rf_wdata=0xCAFE; then count=0 and pend_a=0.
REQ-038 SHALL cover: FIFO holds rd=9 while WB requests continuously -> 3 WB grants, then the 4th cycle grants rd=9 with wb_stall=1; the following cycle grants the held WB.
REQ-039 SHALL cover: 4 pushes with no pops -> lu_ready=0 and count=4; a 5th lu_valid is not accepted; one pop -> lu_ready=1.
REQ-040 SHALL cover: lu push with rd=0 and wb_we with wb_rd=0 -> no push, count stays 0, rf_we=0.
REQ-041 SHALL cover: reset asserted mid-stream with count=3 -> outputs forced per REQ-034 immediately; after release count=0 and the 3 entries are never written.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: merges WB-stage writes with buffered long-latency
// results, with a starvation guard that forces buffered results through.
module rf_write_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wb_we,
    input  logic [4:0]                      wb_rd,
    input  logic [31:0]                     wb_data,
    input  logic                            lu_valid,
    output logic                            lu_ready,
    input  logic [4:0]                      lu_rd,
    input  logic [31:0]                     lu_data,
    output logic                            rf_we,
    output logic [4:0]                      rf_waddr,
    output logic [31:0]                     rf_wdata,
    output logic                            wb_stall,
    input  logic [4:0]                      chk_rd_a,
    input  logic [4:0]                      chk_rd_b,
    output logic                            pend_a,
    output logic                            pend_b,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW     = $clog2(FIFO_DEPTH + 1);
    localparam int SW     = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_WB,
        GRANT_FIFO
    } grant_t;

    logic [ADDR_W-1:0] rd_mem   [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;

    logic          wb_req;
    logic          fifo_ne;
    logic          forced;
    grant_t        grant;
    logic          push;
    logic          pop;
    logic          hit_a;
    logic          hit_b;
    logic [SW-1:0] starve_nxt;

    // Grant selection: forced drain beats WB, WB beats an opportunistic drain.
    always_comb begin
        wb_req  = wb_we && (wb_rd != '0);
        fifo_ne = (count != '0);
        forced  = fifo_ne && (starve_cnt == SW'(STARVE_LIMIT));
        grant   = GRANT_NONE;
        if (forced) begin
            grant = GRANT_FIFO;
        end else if (wb_req) begin
            grant = GRANT_WB;
        end else if (fifo_ne) begin
            grant = GRANT_FIFO;
        end
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        wb_stall = 1'b0;
        if (!reset) begin
            case (grant)
                GRANT_WB: begin
                    rf_we    = 1'b1;
                    rf_waddr = wb_rd;
                    rf_wdata = wb_data;
                end
                GRANT_FIFO: begin
                    rf_we    = 1'b1;
                    rf_waddr = rd_mem[head];
                    rf_wdata = data_mem[head];
                    wb_stall = forced && wb_req;
                end
                default: ;
            endcase
        end
    end

    // lu_ready depends only on registered occupancy, never on lu_valid or the pop.
    assign lu_ready   = !reset && (count < CW'(FIFO_DEPTH));
    assign push       = lu_valid && lu_ready && (lu_rd != '0);
    assign pop        = !reset && (grant == GRANT_FIFO);
    assign fifo_count = count;

    always_comb begin
        starve_nxt = starve_cnt;
        if (!fifo_ne || grant == GRANT_FIFO) begin
            starve_nxt = '0;
        end else if (grant == GRANT_WB && starve_cnt < SW'(STARVE_LIMIT)) begin
            starve_nxt = starve_cnt + SW'(1);
        end
    end

    // Hazard lookup covers every valid slot, including a head that pops this cycle.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            logic [PW-1:0] off;
            off = PW'(i) - head;
            if (CW'(off) < count) begin
                if (rd_mem[i] == chk_rd_a) hit_a = 1'b1;
                if (rd_mem[i] == chk_rd_b) hit_b = 1'b1;
            end
        end
    end

    assign pend_a = !reset && (chk_rd_a != '0) && hit_a;
    assign pend_b = !reset && (chk_rd_b != '0) && hit_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            starve_cnt <= starve_nxt;
        end
    end

    // Entry storage carries no reset; validity is defined by head/count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[tail]   <= lu_rd;
            data_mem[tail] <= lu_data;
        end
    end

endmodule
